// File: rtl/sample_packer_pkg.sv
// Shared definitions for the sample packer: lane counter sizing and the
// largest supported samples-per-word setting.
package packer_pkg;

    localparam int MAX_PARALLEL = 64;

    // Lane counter width; a single-lane packer still needs a 1-bit counter.
    function automatic int lane_width(input int parallel);
        return (parallel > 1) ? $clog2(parallel) : 1;
    endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Sample-stream input and packed-word output bundle of the sample packer.
// The master side produces samples; the slave side is the packer itself.
interface sample_packer_if
    import packer_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PARALLEL       = 10,
    parameter int DROP_CNT_WIDTH = 16
);
    localparam int LANE_W = lane_width(PARALLEL);

    logic [DATA_WIDTH-1:0]          din;
    logic                           din_valid;
    logic                           sync_in;
    logic [DATA_WIDTH*PARALLEL-1:0] dout;
    logic                           dout_valid;
    logic [LANE_W-1:0]              lane_idx;
    logic                           frame_drop;
    logic [DROP_CNT_WIDTH-1:0]      drop_count;

    modport master (
        output din, din_valid, sync_in,
        input  dout, dout_valid, lane_idx, frame_drop, drop_count
    );

    modport slave (
        input  din, din_valid, sync_in,
        output dout, dout_valid, lane_idx, frame_drop, drop_count
    );

endinterface

// File: rtl/sample_packer.sv
// Serial-to-parallel packer: gathers PARALLEL samples into one wide word.
// Define SAMPLE_PACKER_MSB_FIRST_EN to place the first sample in the top lane.
module sample_packer
    import packer_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PARALLEL       = 10,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    sample_packer_if.slave  bus
);
    localparam int LANE_W = lane_width(PARALLEL);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PARALLEL - 1);

    logic [LANE_W-1:0]                   lane_q, lane_d, wr_lane;
    logic [PARALLEL-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [PARALLEL-1:0]                 lane_we;
    logic [DATA_WIDTH*PARALLEL-1:0]      frame_word;
    logic [DATA_WIDTH*PARALLEL-1:0]      dout_q, dout_d;
    logic                                dout_valid_q, dout_valid_d;
    logic                                frame_drop_q, frame_drop_d;
    logic [DROP_CNT_WIDTH-1:0]           drop_count_q, drop_count_d;
    logic                                drop, complete;

    // A sync restarts the frame before this cycle's sample is placed, so a
    // sync on the final lane drops the partial frame instead of completing it.
    always_comb begin : lane_ctrl
        wr_lane  = bus.sync_in ? '0 : lane_q;
        drop     = bus.sync_in && (lane_q != '0);
        complete = bus.din_valid && (wr_lane == LAST_LANE);
        lane_d   = wr_lane;
        if (bus.din_valid) begin
            lane_d = complete ? '0 : wr_lane + 1'b1;
        end
    end

    for (genvar gi = 0; gi < PARALLEL; gi++) begin : g_lane
        assign lane_we[gi]  = bus.din_valid && (wr_lane == LANE_W'(gi));
        assign shadow_d[gi] = lane_we[gi] ? bus.din : shadow_q[gi];
`ifdef SAMPLE_PACKER_MSB_FIRST_EN
        assign frame_word[(PARALLEL-1-gi)*DATA_WIDTH +: DATA_WIDTH] = shadow_d[gi];
`else
        assign frame_word[gi*DATA_WIDTH +: DATA_WIDTH] = shadow_d[gi];
`endif
    end

    always_comb begin : out_ctrl
        dout_d       = complete ? frame_word : dout_q;
        dout_valid_d = complete;
        frame_drop_d = drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_drop_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            lane_q       <= lane_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_drop_q <= frame_drop_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.lane_idx   = lane_q;
    assign bus.frame_drop = frame_drop_q;
    assign bus.drop_count = drop_count_q;

endmodule
